// File: rtl/wb_frame_bridge_pkg.sv
// Shared definitions for the Wishbone frame bridge: register addresses,
// sequencer state encoding, STATUS field offsets and control-bit indices.
// Optional feature macro: WB_FRAME_BRIDGE_IRQ_EN (adds o_irq / STATUS irq bit).
package wb_frame_bridge_pkg;

  // Register map
  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_TXLEN  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RXDATA = 2'd3;

  // Frame sequencer states (encoding is software visible in STATUS)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } seq_state_e;

  // STATUS write control bits
  localparam int unsigned ABORT_BIT   = 0;
  localparam int unsigned CLR_ERR_BIT = 1;
  localparam int unsigned IRQ_CLR_BIT = 2;

  // STATUS read field offsets; remaining occupies [lw-1:0]
  function automatic int unsigned status_full_bit(input int unsigned lw);
    return lw;
  endfunction

  function automatic int unsigned status_empty_bit(input int unsigned lw);
    return lw + 1;
  endfunction

  function automatic int unsigned status_state_lsb(input int unsigned lw);
    return lw + 2;
  endfunction

  function automatic int unsigned status_err_bit(input int unsigned lw);
    return lw + 4;
  endfunction

  function automatic int unsigned status_irq_bit(input int unsigned lw);
    return lw + 5;
  endfunction

endpackage

// File: rtl/frame_sequencer.sv
// Frame sequencer: tracks a programmed frame length, counts pushed words down,
// fires a one-cycle MAC start pulse with the last word and waits for done.
// Ports: clk/rst; load+len arm a frame (IDLE only); push counts one word;
// abort drops a frame being loaded; tx_done ends COMMIT.
// Outputs: state, remaining (registered), tx_start (registered pulse).
module frame_sequencer
  import wb_frame_bridge_pkg::*;
#(
  parameter int unsigned LW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [LW-1:0] len,
  input  logic          push,
  input  logic          abort,
  input  logic          tx_done,
  output seq_state_e    state,
  output logic [LW-1:0] remaining,
  output logic          tx_start
);

  seq_state_e    state_d;
  logic [LW-1:0] remaining_d;
  logic          tx_start_d;

  // State, counter and start pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      tx_start  <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      tx_start  <= tx_start_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    tx_start_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_d     = ST_LOAD;
          remaining_d = len;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (push) begin
          remaining_d = remaining - LW'(1);
          // Last word: start the MAC alongside the FIFO write of this word
          if (remaining == LW'(1)) begin
            state_d    = ST_COMMIT;
            tx_start_d = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        if (tx_done) state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/wb_frame_bridge.sv
// Pipelined Wishbone slave bridging the CPU bus to the Ethernet MAC TX/RX FIFOs.
// Ports: Wishbone slave (i_wb_*/o_wb_*; o_wb_stall is combinational),
// TX FIFO push (i_txf_full, o_txf_wr, o_txf_data), RX FIFO FWFT pop
// (i_rxf_empty, i_rxf_data, o_rxf_rd), MAC handshake (o_tx_start, i_tx_done).
// Optional: `define WB_FRAME_BRIDGE_IRQ_EN adds the o_irq level output.
module wb_frame_bridge
  import wb_frame_bridge_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [1:0]    i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_txf_full,
  output logic          o_txf_wr,
  output logic [DW-1:0] o_txf_data,
  input  logic          i_rxf_empty,
  input  logic [DW-1:0] i_rxf_data,
  output logic          o_rxf_rd,
  output logic          o_tx_start,
  input  logic          i_tx_done
`ifdef WB_FRAME_BRIDGE_IRQ_EN
  ,
  output logic          o_irq
`endif
);

  localparam int unsigned S_FULL  = status_full_bit(LW);
  localparam int unsigned S_EMPTY = status_empty_bit(LW);
  localparam int unsigned S_ST    = status_state_lsb(LW);
  localparam int unsigned S_ERR   = status_err_bit(LW);

  seq_state_e    state;
  logic [LW-1:0] remaining;
  logic [LW-1:0] len;
  logic          err;

  logic          accept_c;
  logic          wr_c;
  logic          rd_c;
  logic          load_c;
  logic          push_c;
  logic          abort_c;
  logic          err_set_c;
  logic          err_clr_c;
  logic          rx_pop_c;
  logic [DW-1:0] status_c;
  logic [DW-1:0] rdata_c;

  // Only a TXDATA write into a full FIFO holds the bus
  assign o_wb_stall = i_wb_stb && i_wb_we && (i_wb_addr == ADDR_TXDATA) && i_txf_full;

  // Bus decode
  always_comb begin
    accept_c  = i_wb_cyc && i_wb_stb && !o_wb_stall;
    wr_c      = accept_c && i_wb_we;
    rd_c      = accept_c && !i_wb_we;
    load_c    = wr_c && (i_wb_addr == ADDR_TXLEN) && (state == ST_IDLE)
                && (i_wb_data[LW-1:0] != '0);
    push_c    = wr_c && (i_wb_addr == ADDR_TXDATA) && (state == ST_LOAD);
    abort_c   = wr_c && (i_wb_addr == ADDR_STATUS) && i_wb_data[ABORT_BIT];
    err_clr_c = wr_c && (i_wb_addr == ADDR_STATUS) && i_wb_data[CLR_ERR_BIT];
    // Pushing outside LOAD, or reprogramming length mid-frame, is a software error
    err_set_c = wr_c && (((i_wb_addr == ADDR_TXDATA) && (state != ST_LOAD))
                      || ((i_wb_addr == ADDR_TXLEN) && (state != ST_IDLE)));
    rx_pop_c  = rd_c && (i_wb_addr == ADDR_RXDATA) && !i_rxf_empty;
  end

`ifdef WB_FRAME_BRIDGE_IRQ_EN
  localparam int unsigned S_IRQ = status_irq_bit(LW);

  logic irq;
  logic irq_set_c;
  logic irq_clr_c;

  assign irq_set_c = (i_tx_done && (state == ST_COMMIT)) || (err_set_c && !err);
  assign irq_clr_c = wr_c && (i_wb_addr == ADDR_STATUS) && i_wb_data[IRQ_CLR_BIT];
  assign o_irq     = irq;

  // Interrupt level; a new event wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            irq <= 1'b0;
    else if (irq_set_c) irq <= 1'b1;
    else if (irq_clr_c) irq <= 1'b0;
  end
`endif

  // STATUS register image
  always_comb begin
    status_c              = '0;
    status_c[LW-1:0]      = remaining;
    status_c[S_FULL]      = i_txf_full;
    status_c[S_EMPTY]     = i_rxf_empty;
    status_c[S_ST +: 2]   = state;
    status_c[S_ERR]       = err;
`ifdef WB_FRAME_BRIDGE_IRQ_EN
    status_c[S_IRQ]       = irq;
`endif
  end

  // Read data mux
  always_comb begin
    rdata_c = '0;
    case (i_wb_addr)
      ADDR_TXLEN:  rdata_c = DW'(len);
      ADDR_STATUS: rdata_c = status_c;
      ADDR_RXDATA: if (!i_rxf_empty) rdata_c = i_rxf_data;
      default:     rdata_c = '0;
    endcase
  end

  // Bus response, FIFO strobes and register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wb_ack   <= 1'b0;
      o_wb_data  <= '0;
      o_txf_wr   <= 1'b0;
      o_txf_data <= '0;
      o_rxf_rd   <= 1'b0;
      len        <= '0;
      err        <= 1'b0;
    end else begin
      o_wb_ack  <= accept_c;
      o_wb_data <= rd_c ? rdata_c : '0;
      o_txf_wr  <= push_c;
      o_rxf_rd  <= rx_pop_c;
      if (push_c)         o_txf_data <= i_wb_data;
      if (load_c)         len        <= i_wb_data[LW-1:0];
      if (err_set_c)      err        <= 1'b1;
      else if (err_clr_c) err        <= 1'b0;
    end
  end

  frame_sequencer #(
    .LW (LW)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .len       (i_wb_data[LW-1:0]),
    .push      (push_c),
    .abort     (abort_c),
    .tx_done   (i_tx_done),
    .state     (state),
    .remaining (remaining),
    .tx_start  (o_tx_start)
  );

endmodule

// File: tb/tb_wb_frame_bridge.sv
// Self-checking bench for wb_frame_bridge: directed vector table, hand-written
// corner sequences (stall, tx_done/TXLEN collision, cyc=0, async reset) and a
// randomized phase checked against a transaction-level reference model.
module tb_wb_frame_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [1:0]    addr;
  logic [DW-1:0] wdata;
  logic          ack, stall;
  logic [DW-1:0] rdata;
  logic          txf_full, txf_wr;
  logic [DW-1:0] txf_data;
  logic          rxf_empty, rxf_rd;
  logic [DW-1:0] rxf_data;
  logic          tx_start, tx_done;
`ifdef WB_FRAME_BRIDGE_IRQ_EN
  logic          irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_frame_bridge #(.DW(DW), .LW(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_wb_cyc   (cyc),
    .i_wb_stb   (stb),
    .i_wb_we    (we),
    .i_wb_addr  (addr),
    .i_wb_data  (wdata),
    .o_wb_ack   (ack),
    .o_wb_stall (stall),
    .o_wb_data  (rdata),
    .i_txf_full (txf_full),
    .o_txf_wr   (txf_wr),
    .o_txf_data (txf_data),
    .i_rxf_empty(rxf_empty),
    .i_rxf_data (rxf_data),
    .o_rxf_rd   (rxf_rd),
    .o_tx_start (tx_start),
    .i_tx_done  (tx_done)
`ifdef WB_FRAME_BRIDGE_IRQ_EN
    ,
    .o_irq      (irq)
`endif
  );

  typedef struct {
    bit          we;
    logic [1:0]  a;
    logic [31:0] d;
    bit          done;
    bit          emp;
    logic [31:0] rxd;
    logic [31:0] er;
    bit          ew;
    logic [31:0] ewd;
    bit          es;
    bit          erd;
  } vec_t;

  vec_t vq[$];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // STATUS image from its fields (LW=9 layout)
  function automatic logic [31:0] sw(input int rem, input bit full, input bit empty,
                                     input int st, input bit err);
    return 32'(rem) | (32'(full) << 9) | (32'(empty) << 10) | (32'(st) << 11) | (32'(err) << 13);
  endfunction

  function automatic vec_t mk(input bit w, input logic [1:0] a, input logic [31:0] d,
                              input bit done, input bit emp, input logic [31:0] rxd,
                              input logic [31:0] er, input bit ew, input logic [31:0] ewd,
                              input bit es, input bit erd);
    vec_t v;
    v.we = w; v.a = a; v.d = d; v.done = done; v.emp = emp; v.rxd = rxd;
    v.er = er; v.ew = ew; v.ewd = ewd; v.es = es; v.erd = erd;
    return v;
  endfunction

  // One bus transaction; waits out a stall (releasing txf_full after 'hold' cycles)
  task automatic do_op(input string name, input bit w, input logic [1:0] a,
                       input logic [31:0] d, input bit done, input int hold,
                       input logic [31:0] er, input bit ew, input logic [31:0] ewd,
                       input bit es, input bit erd);
    int waited;
    waited = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; tx_done = done;
    #1;
    while (stall && waited < 50) begin
      @(posedge clk); #1;
      check_eq({name, "_stall_ack"}, 64'(ack), 64'd0);
      check_eq({name, "_stall_push"}, 64'(txf_wr), 64'd0);
      @(negedge clk);
      waited++;
      if (waited >= hold) txf_full = 1'b0;
      #1;
    end
    if (stall) check_eq({name, "_stall_timeout"}, 64'(stall), 64'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; tx_done = 1'b0;
    check_eq({name, "_ack"}, 64'(ack), 64'd1);
    if (!w) check_eq({name, "_rdata"}, 64'(rdata), 64'(er));
    check_eq({name, "_txf_wr"}, 64'(txf_wr), 64'(ew));
    if (ew) check_eq({name, "_txf_data"}, 64'(txf_data), 64'(ewd));
    check_eq({name, "_tx_start"}, 64'(tx_start), 64'(es));
    check_eq({name, "_rxf_rd"}, 64'(rxf_rd), 64'(erd));
    @(posedge clk); #1;
    check_eq({name, "_ack_once"}, 64'(ack), 64'd0);
    check_eq({name, "_pulses_once"}, 64'({txf_wr, tx_start, rxf_rd}), 64'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", 64'({ack, txf_wr, rxf_rd, tx_start}), 64'd0);
    check_eq("reset_rdata", 64'(rdata), 64'd0);
    check_eq("reset_txf_data", 64'(txf_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model state
  int          m_st, m_len, m_rem;
  bit          m_err;

  initial begin
    logic [31:0] er, d;
    logic [1:0]  a;
    bit          w, ew, es, erd, done, full_acc;
    int          r, hold;

    cyc = 0; stb = 0; we = 0; addr = 0; wdata = 0;
    txf_full = 0; rxf_empty = 1; rxf_data = 0; tx_done = 0; rst = 1;
    apply_reset();

    // Directed vector table
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(0,0,1,0,0), 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(3,0,1,1,0), 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 32'h1111_1111, 0, 1, 0, 0, 1, 32'h1111_1111, 0, 0));
    vq.push_back(mk(1, 0, 32'h2222_2222, 0, 1, 0, 0, 1, 32'h2222_2222, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(1,0,1,1,0), 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 32'h3333_3333, 0, 1, 0, 0, 1, 32'h3333_3333, 1, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(0,0,1,2,0), 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(0,0,1,0,0), 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 32'h4444_4444, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(0,0,1,0,1), 0, 0, 0, 0));
    vq.push_back(mk(1, 2, 2, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(0,0,1,0,0), 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 32'h5555_0001, 0, 1, 0, 0, 1, 32'h5555_0001, 0, 0));
    vq.push_back(mk(1, 0, 32'h5555_0002, 0, 1, 0, 0, 1, 32'h5555_0002, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(2,0,1,1,0), 0, 0, 0, 0));
    vq.push_back(mk(1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(0,0,1,0,0), 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 1, 0, 4, 0, 0, 0, 0));
    vq.push_back(mk(0, 3, 0, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0, 1));
    vq.push_back(mk(0, 3, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 32'hFFFF_FE00, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(0,0,1,0,0), 0, 0, 0, 0));
    vq.push_back(mk(1, 3, 123, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(0,0,1,0,0), 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(2,0,1,1,1), 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 0));
    vq.push_back(mk(1, 2, 3, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 2, 0, 0, 1, 0, sw(0,0,1,0,0), 0, 0, 0, 0));

    foreach (vq[i]) begin
      rxf_empty = vq[i].emp;
      rxf_data  = vq[i].rxd;
      do_op($sformatf("vec%0d", i), vq[i].we, vq[i].a, vq[i].d, vq[i].done, 0,
            vq[i].er, vq[i].ew, vq[i].ewd, vq[i].es, vq[i].erd);
    end
    rxf_empty = 1'b1;

    // Stall: full FIFO holds a TXDATA write until it drains
    do_op("stall_len", 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    txf_full = 1'b1;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = 0; wdata = 32'hA5A5_0001;
    #1;
    check_eq("stall_high", 64'(stall), 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("stall_no_ack", 64'(ack), 64'd0);
      check_eq("stall_no_push", 64'(txf_wr), 64'd0);
      check_eq("stall_held", 64'(stall), 64'd1);
    end
    @(negedge clk);
    txf_full = 1'b0;
    #1;
    check_eq("stall_released", 64'(stall), 64'd0);
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    check_eq("stall_ack", 64'(ack), 64'd1);
    check_eq("stall_push", 64'(txf_wr), 64'd1);
    check_eq("stall_push_data", 64'(txf_data), 64'h0000_0000_A5A5_0001);
    do_op("stall_status", 0, 2, 0, 0, 0, sw(1,0,1,1,0), 0, 0, 0, 0);
    do_op("stall_last", 1, 0, 32'hA5A5_0002, 0, 0, 0, 1, 32'hA5A5_0002, 1, 0);
    do_op("stall_done", 0, 2, 0, 1, 0, sw(0,0,1,2,0), 0, 0, 0, 0);

    // tx_done colliding with a TXLEN write: write still sees COMMIT
    do_op("col_len", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    do_op("col_push", 1, 0, 32'h7777_0001, 0, 0, 0, 1, 32'h7777_0001, 1, 0);
    do_op("col_len_done", 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    do_op("col_status", 0, 2, 0, 0, 0, sw(0,0,1,0,1), 0, 0, 0, 0);
    do_op("col_txlen", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    do_op("col_clr", 1, 2, 2, 0, 0, 0, 0, 0, 0, 0);

    // Strobe without cyc is never accepted
    @(negedge clk);
    cyc = 0; stb = 1; we = 1; addr = 1; wdata = 5;
    @(posedge clk); #1;
    stb = 0; we = 0;
    @(posedge clk); #1;
    check_eq("nocyc_ack", 64'(ack), 64'd0);
    do_op("nocyc_txlen", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    do_op("nocyc_status", 0, 2, 0, 0, 0, sw(0,0,1,0,0), 0, 0, 0, 0);

    // Asynchronous reset mid-frame (LOAD, remaining=2)
    do_op("rst_len", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = 0; wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    check_eq("rst_pre_push", 64'(txf_wr), 64'd1);
    check_eq("rst_pre_ack", 64'(ack), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_push", 64'(txf_wr), 64'd0);
    check_eq("rst_async_ack", 64'(ack), 64'd0);
    check_eq("rst_async_data", 64'(txf_data), 64'd0);
    check_eq("rst_async_start", 64'(tx_start), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("rst_status", 0, 2, 0, 0, 0, sw(0,0,1,0,0), 0, 0, 0, 0);
    do_op("rst_txlen", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    do_op("rst_len1", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    do_op("rst_push1", 1, 0, 32'hCAFE_0002, 0, 0, 0, 1, 32'hCAFE_0002, 1, 0);
    do_op("rst_commit", 0, 2, 0, 1, 0, sw(0,0,1,2,0), 0, 0, 0, 0);
    do_op("rst_idle", 0, 2, 0, 0, 0, sw(0,0,1,0,0), 0, 0, 0, 0);

    // Randomized phase against the reference model
    apply_reset();
    m_st = 0; m_len = 0; m_rem = 0; m_err = 0;
    for (int it = 0; it < 300; it++) begin
      r         = $urandom_range(0, 9);
      txf_full  = ($urandom_range(0, 3) == 0);
      rxf_empty = $urandom_range(0, 1);
      rxf_data  = $urandom;
      hold      = $urandom_range(1, 3);
      d         = $urandom;
      done      = (r >= 4) && ($urandom_range(0, 3) == 0);
      case (r)
        0, 1, 2, 3: begin w = 1; a = 2'd0; end
        4:          begin w = 1; a = 2'd1; d = (d & 32'hFFFF_FE00) | 32'($urandom_range(0, 4)); end
        5:          begin w = 1; a = 2'd2; end
        6:          begin w = 0; a = 2'd2; end
        7:          begin w = 0; a = 2'd3; end
        8:          begin w = 0; a = 2'($urandom_range(0, 1)); end
        default:    begin w = 1; a = 2'd3; end
      endcase
      full_acc = (w && a == 2'd0) ? 1'b0 : txf_full;
      er = 0; ew = 0; es = 0; erd = 0;
      if (w) begin
        case (a)
          2'd0: if (m_st == 1) begin
                  ew = 1;
                  m_rem = m_rem - 1;
                  if (m_rem == 0) begin m_st = 2; es = 1; end
                end else m_err = 1;
          2'd1: if (m_st == 0) begin
                  if ((d % 512) != 0) begin m_len = int'(d % 512); m_rem = m_len; m_st = 1; end
                end else m_err = 1;
          2'd2: begin
                  if (d[0] && m_st == 1) begin m_st = 0; m_rem = 0; end
                  if (d[1]) m_err = 0;
                end
          default: ;
        endcase
      end else begin
        case (a)
          2'd1: er = 32'(m_len);
          2'd2: er = sw(m_rem, full_acc, rxf_empty, m_st, m_err);
          2'd3: if (!rxf_empty) begin er = rxf_data; erd = 1; end
          default: er = 0;
        endcase
      end
      if (done && m_st == 2) m_st = 0;
      do_op($sformatf("rnd%0d", it), w, a, d, done, hold, er, ew, d, es, erd);
    end
    txf_full = 0; rxf_empty = 1;
    do_op("rnd_final", 0, 2, 0, 0, 0, sw(m_rem, 0, 1, m_st, m_err), 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
